// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared sizes, FSM state encoding and index helper for the 8-way round-robin arbiter
package rr_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_t;

    // Next requester index after idx, wrapping 7 -> 0 through the natural 3-bit overflow.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/decoder3x8.sv
// rtl/decoder3x8.sv - 3-bit binary index to 8-bit one-hot decoder
module decoder3x8 (
    input  logic [2:0] addr,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'b0000_0001 << addr;
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with one-cycle release gap; RR_ARB_TIMEOUT_EN adds a MAX_HOLD forced release
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_addr,
    output logic             grant_valid,
    output logic             timeout
);

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
        $error("rr_arbiter8: MAX_HOLD must be within 1..255");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] pick_off;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             natural_release;
    logic [N_REQ-1:0] addr_onehot;

    // Rotate so that bit 0 is the requester at ptr; the lowest set bit is then the winner.
    always_comb begin
        req_rot  = N_REQ'({req, req} >> ptr);
        pick_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = k[IDX_W-1:0];
            end
        end
    end

    assign pick_idx        = ptr + pick_off;
    assign pick_found      = |req;
    assign natural_release = done || !req[grant_addr];

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt;
    logic       timeout_q;
    logic       hold_expired;

    // hold_cnt counts completed GRANT cycles, so the current cycle is number hold_cnt+1.
    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign timeout      = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_addr  <= '0;
            grant_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        grant_addr  <= pick_idx;
                        grant_valid <= 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt    <= '0;
`endif
                    end
                end

                GRANT: begin
                    if (natural_release) begin
                        state       <= RELEASE;
                        grant_valid <= 1'b0;
                        ptr         <= next_idx(grant_addr);
`ifdef RR_ARB_TIMEOUT_EN
                    end else if (hold_expired) begin
                        state       <= RELEASE;
                        grant_valid <= 1'b0;
                        ptr         <= next_idx(grant_addr);
                        timeout_q   <= 1'b1;
                    end else begin
                        hold_cnt    <= hold_cnt + 8'd1;
`endif
                    end
                end

                RELEASE: begin
                    state <= IDLE;
                end

                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    decoder3x8 u_decoder (
        .addr   (grant_addr),
        .onehot (addr_onehot)
    );

    assign grant = addr_onehot & {N_REQ{grant_valid}};

endmodule
